// File: rtl/multi_4x3bit.sv
// Two-stage unsigned multiplier: an AND-array of partial products is registered,
// then summed by a chain of ripple-carry adders into the product register.
module multi_4x3bit #(
  parameter int A_W = 3,
  parameter int B_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [A_W-1:0]       a,
  input  logic [B_W-1:0]       b,
  output logic                 out_valid,
  output logic [A_W+B_W-1:0]   c
);

  localparam int P_W = A_W + B_W;

  logic [A_W-1:0][P_W-1:0] pp_d;
  logic [A_W-1:0][P_W-1:0] pp_q;
  logic                    v1_q;
  logic [P_W-1:0]          sum_d;
  logic [P_W-1:0]          c_q;
  logic                    out_valid_q;

  // Bit-serial ripple-carry adder; the carry out is dropped because P_W never overflows.
  function automatic logic [P_W-1:0] rca(input logic [P_W-1:0] x, input logic [P_W-1:0] y);
    logic           carry;
    logic [P_W-1:0] s;
    carry = 1'b0;
    s     = '0;
    for (int k = 0; k < P_W; k++) begin
      s[k]  = x[k] ^ y[k] ^ carry;
      carry = (x[k] & y[k]) | (carry & (x[k] ^ y[k]));
    end
    return s;
  endfunction

  always_comb begin
    pp_d = '0;
    for (int i = 0; i < A_W; i++) begin
      pp_d[i] = {P_W{a[i]}} & ({{A_W{1'b0}}, b} << i);
    end
  end

  always_comb begin
    sum_d = pp_q[0];
    for (int i = 1; i < A_W; i++) begin
      sum_d = rca(sum_d, pp_q[i]);
    end
  end

  // Partial products load only on valid input, so idle-cycle X on a/b never enters the pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pp_q <= '0;
      v1_q <= 1'b0;
    end else begin
      v1_q <= in_valid;
      if (in_valid) begin
        pp_q <= pp_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= v1_q;
      if (v1_q) begin
        c_q <= sum_d;
      end
    end
  end

  assign c         = c_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_multi_4x3bit.sv
// Directed self-checking bench for multi_4x3bit: inputs driven and outputs checked on the falling edge.
module tb_multi_4x3bit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [2:0] a;
  logic [3:0] b;
  logic       out_valid;
  logic [6:0] c;

  int n_cmp;
  int n_err;
  int ov_count;

  int s_a   [7] = '{1, 2, 3, 4, 5, 6, 7};
  int s_b   [7] = '{2, 3, 4, 3, 6, 5, 7};
  int s_exp [7] = '{2, 6, 12, 12, 30, 30, 49};

  multi_4x3bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .c         (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic single_op(input logic [2:0] av, input logic [3:0] bv, input logic [7:0] exp);
    @(negedge clk);
    in_valid = 1'b1; a = av; b = bv;
    @(negedge clk);
    in_valid = 1'b0; a = 3'd0; b = 4'd0;
    check("single_ov_early", {7'd0, out_valid}, 8'd0);
    @(negedge clk);
    check("single_ov", {7'd0, out_valid}, 8'd1);
    check("single_c", {1'b0, c}, exp);
    @(negedge clk);
    check("single_ov_drop", {7'd0, out_valid}, 8'd0);
    check("single_c_hold", {1'b0, c}, exp);
  endtask

  initial begin
    logic [6:0] idx;
    n_cmp = 0; n_err = 0; ov_count = 0;
    rst = 1'b1; in_valid = 1'b0; a = 3'd0; b = 4'd0;
    #1;
    check("reset_c", {1'b0, c}, 8'd0);
    check("reset_ov", {7'd0, out_valid}, 8'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Fill pipe, then reset asynchronously with a product in flight.
    @(negedge clk);
    in_valid = 1'b1; a = 3'd3; b = 4'd4;
    @(negedge clk);
    a = 3'd7; b = 4'd15;
    @(negedge clk);
    check("pre_rst_c", {1'b0, c}, 8'd12);
    check("pre_rst_ov", {7'd0, out_valid}, 8'd1);
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("async_rst_c", {1'b0, c}, 8'd0);
    check("async_rst_ov", {7'd0, out_valid}, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("no_stale_ov", {7'd0, out_valid}, 8'd0);
      check("no_stale_c", {1'b0, c}, 8'd0);
    end

    single_op(3'd0, 4'd0, 8'd0);
    single_op(3'd1, 4'd2, 8'd2);
    single_op(3'd2, 4'd3, 8'd6);
    single_op(3'd3, 4'd4, 8'd12);

    // Back-to-back stream of seven pairs.
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        check("stream_ov", {7'd0, out_valid}, 8'd1);
        check("stream_c", {1'b0, c}, s_exp[k-2][7:0]);
      end
      if (k < 7) begin
        in_valid = 1'b1; a = s_a[k][2:0]; b = s_b[k][3:0];
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("stream_end_ov", {7'd0, out_valid}, 8'd0);

    single_op(3'd7, 4'd15, 8'd105);
    single_op(3'd7, 4'd0, 8'd0);
    single_op(3'd0, 4'd15, 8'd0);
    single_op(3'd4, 4'd8, 8'd32);

    // Idle with junk and X on operands: product must hold.
    single_op(3'd5, 4'd6, 8'd30);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (k == 3) begin
        a = 3'bxxx; b = 4'bxxxx;
      end else begin
        a = 3'($urandom_range(7)); b = 4'($urandom_range(15));
      end
      check("idle_ov", {7'd0, out_valid}, 8'd0);
      check("idle_c", {1'b0, c}, 8'd30);
    end

    // Exhaustive stream of all 128 operand pairs.
    for (int k = 0; k < 130; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        int j;
        j = k - 2;
        if (out_valid === 1'b1) ov_count++;
        check("exh_c", {1'b0, c}, 8'((j >> 4) * (j & 15)));
      end
      if (k < 128) begin
        idx = k[6:0];
        in_valid = 1'b1; a = idx[6:4]; b = idx[3:0];
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    if (out_valid === 1'b1) ov_count++;
    check("exh_ov_count", 8'(ov_count), 8'd128);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
